// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave memory: response codes and path states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write path: idle/collecting AW and W, or holding a B response.
    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    // Read path: idle, ARREADY raised awaiting handshake, or holding R data.
    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_byte_ram.sv
// DEPTH x DATA_W word memory with per-byte write enables, synchronous clear and async read.
// Latency: write lands at the clock edge, read is combinational from raddr.
// Backpressure: none; clear takes priority over a write in the same cycle.
module axi_lite_byte_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear all words, or write the enabled byte lanes of one word.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a byte-strobed word memory; optional preload port under AXI_SLV_PRELOAD_EN.
// Latency: xREADY one cycle after request, B one cycle after AW+W latched, R one cycle after AR handshake.
// Backpressure: one outstanding write and one outstanding read; B/R held until BREADY/RREADY.
module axi_lite_slave_mem #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  AWVALID,
    input  logic [ADDR_W-1:0]     AWADDR,
    output logic                  AWREADY,
    input  logic                  WVALID,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WREADY,
    input  logic                  BREADY,
    output logic                  BVALID,
    output logic [1:0]            BRESP,
    input  logic                  ARVALID,
    input  logic [ADDR_W-1:0]     ARADDR,
    output logic                  ARREADY,
    input  logic                  RREADY,
    output logic                  RVALID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    input  logic                  valid,
    input  logic                  read_valid,
    input  logic [ADDR_W-1:0]     aw_addr,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_strb,
    output logic                  ready
);
    import axi_lite_pkg::*;

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_LIMIT;
    endfunction

    wr_state_t             wr_state, wr_state_nxt;
    rd_state_t             rd_state, rd_state_nxt;
    logic                  aw_lat, aw_lat_nxt, w_lat, w_lat_nxt;
    logic [ADDR_W-1:0]     aw_addr_q, aw_addr_nxt;
    logic [DATA_W-1:0]     w_data_q, w_data_nxt;
    logic [STRB_W-1:0]     w_strb_q, w_strb_nxt;
    logic                  awready_nxt, wready_nxt, bvalid_nxt, arready_nxt, rvalid_nxt, ready_nxt;
    logic [1:0]            bresp_nxt, rresp_nxt;
    logic [DATA_W-1:0]     rdata_nxt;

    logic                  ram_we;
    logic [IDX_W-1:0]      ram_waddr;
    logic [DATA_W-1:0]     ram_wdata, ram_rdata;
    logic [STRB_W-1:0]     ram_be;

`ifndef AXI_SLV_PRELOAD_EN
    logic unused_preload;
    assign unused_preload = ^{aw_addr, w_data, w_strb};
`endif

    axi_lite_byte_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
        .clk   (ACLK),
        .clr   (ARESET),
        .we    (ram_we),
        .be    (ram_be),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ARADDR[2 +: IDX_W]),
        .rdata (ram_rdata)
    );

    // Next-state and next-output decode for both independent paths.
    always_comb begin
        wr_state_nxt = wr_state;
        rd_state_nxt = rd_state;
        aw_lat_nxt   = aw_lat;
        aw_addr_nxt  = aw_addr_q;
        w_lat_nxt    = w_lat;
        w_data_nxt   = w_data_q;
        w_strb_nxt   = w_strb_q;
        bvalid_nxt   = BVALID;
        bresp_nxt    = BRESP;
        rvalid_nxt   = RVALID;
        rdata_nxt    = RDATA;
        rresp_nxt    = RRESP;
        arready_nxt  = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = aw_addr_q[2 +: IDX_W];
        ram_wdata    = w_data_q;
        ram_be       = w_strb_q;

        // AWREADY/WREADY are single-cycle pulses; an accepted beat is never aborted by valid.
        awready_nxt = AWVALID && valid && !aw_lat && !BVALID && !AWREADY;
        wready_nxt  = WVALID  && valid && !w_lat  && !BVALID && !WREADY;
        if (AWVALID && AWREADY) begin
            aw_lat_nxt  = 1'b1;
            aw_addr_nxt = AWADDR;
        end
        if (WVALID && WREADY) begin
            w_lat_nxt  = 1'b1;
            w_data_nxt = WDATA;
            w_strb_nxt = WSTRB;
        end

`ifdef AXI_SLV_PRELOAD_EN
        // Side-band preload only when the AXI write path is completely quiet.
        if (valid && !AWVALID && !aw_lat && !w_lat && !BVALID) begin
            ram_we    = in_range(aw_addr);
            ram_waddr = aw_addr[2 +: IDX_W];
            ram_wdata = w_data;
            ram_be    = w_strb;
        end
`endif

        case (wr_state)
            WR_IDLE: begin
                if (aw_lat && w_lat) begin
                    ram_we       = in_range(aw_addr_q);
                    bresp_nxt    = in_range(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
                    bvalid_nxt   = 1'b1;
                    aw_lat_nxt   = 1'b0;
                    w_lat_nxt    = 1'b0;
                    wr_state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BREADY) begin
                    bvalid_nxt   = 1'b0;
                    wr_state_nxt = WR_IDLE;
                end
            end
        endcase

        // Read data is sampled at the AR handshake edge, so a same-edge write is not visible.
        case (rd_state)
            RD_IDLE: begin
                if (ARVALID && read_valid) begin
                    arready_nxt  = 1'b1;
                    rd_state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ARVALID) begin
                    rvalid_nxt   = 1'b1;
                    rdata_nxt    = in_range(ARADDR) ? ram_rdata : '0;
                    rresp_nxt    = in_range(ARADDR) ? RESP_OKAY : RESP_SLVERR;
                    rd_state_nxt = RD_DATA;
                end else begin
                    rd_state_nxt = RD_IDLE;
                end
            end
            RD_DATA: begin
                if (RREADY) begin
                    rvalid_nxt   = 1'b0;
                    rdata_nxt    = '0;
                    rd_state_nxt = RD_IDLE;
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase

        ready_nxt = !(aw_lat_nxt || w_lat_nxt || bvalid_nxt || rvalid_nxt);
    end

    // State, latches and all outputs registered; reset drops any in-flight transaction.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state  <= WR_IDLE;
            rd_state  <= RD_IDLE;
            aw_lat    <= 1'b0;
            aw_addr_q <= '0;
            w_lat     <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= '0;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RDATA     <= '0;
            RRESP     <= '0;
            ready     <= 1'b0;
        end else begin
            wr_state  <= wr_state_nxt;
            rd_state  <= rd_state_nxt;
            aw_lat    <= aw_lat_nxt;
            aw_addr_q <= aw_addr_nxt;
            w_lat     <= w_lat_nxt;
            w_data_q  <= w_data_nxt;
            w_strb_q  <= w_strb_nxt;
            AWREADY   <= awready_nxt;
            WREADY    <= wready_nxt;
            BVALID    <= bvalid_nxt;
            BRESP     <= bresp_nxt;
            ARREADY   <= arready_nxt;
            RVALID    <= rvalid_nxt;
            RDATA     <= rdata_nxt;
            RRESP     <= rresp_nxt;
            ready     <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem: write/read paths, strobes, range errors, qualifiers, reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: BREADY/RREADY held low for several cycles to check response hold.
module tb_axi_lite_slave_mem;

    logic        ACLK;
    logic        ARESET;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BREADY, BVALID;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic        RREADY, RVALID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        valid, read_valid;
    logic [31:0] aw_addr, w_data;
    logic [3:0]  w_strb;
    logic        ready;

    int checks = 0;
    int errors = 0;

    axi_lite_slave_mem dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
        .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
        .BREADY(BREADY), .BVALID(BVALID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
        .RREADY(RREADY), .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP),
        .valid(valid), .read_valid(read_valid),
        .aw_addr(aw_addr), .w_data(w_data), .w_strb(w_strb),
        .ready(ready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // AWREADY must rise the cycle after the request, then handshake on the next edge.
    task automatic send_aw(input logic [31:0] a);
        AWADDR = a; AWVALID = 1'b1;
        tick();
        chk("awready_rise", AWREADY, 1);
        tick();
        AWVALID = 1'b0;
        chk("awready_pulse", AWREADY, 0);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        tick();
        chk("wready_rise", WREADY, 1);
        tick();
        WVALID = 1'b0;
        chk("wready_pulse", WREADY, 0);
    endtask

    task automatic wait_b();
        int n = 0;
        while (!BVALID && n < 8) begin
            tick();
            n++;
        end
        chk("bvalid_seen", BVALID, 1);
    endtask

    task automatic finish_b(input logic [1:0] resp);
        wait_b();
        chk("bresp", BRESP, resp);
        chk("ready_busy_b", ready, 0);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("bvalid_drop", BVALID, 0);
        chk("ready_after_b", ready, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        ARADDR = a; ARVALID = 1'b1; read_valid = 1'b1;
        tick();
        chk("arready_rise", ARREADY, 1);
        tick();
        ARVALID = 1'b0;
        chk("arready_pulse", ARREADY, 0);
        chk("rvalid", RVALID, 1);
        chk("rdata", RDATA, d);
        chk("rresp", RRESP, resp);
        tick();
        chk("rvalid_hold", RVALID, 1);
        chk("rdata_hold", RDATA, d);
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        chk("rvalid_drop", RVALID, 0);
        chk("rdata_clear", RDATA, 0);
        chk("ready_after_r", ready, 1);
    endtask

    initial begin
        ARESET = 1'b1;
        AWVALID = 0; AWADDR = 0; WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
        ARVALID = 0; ARADDR = 0; RREADY = 0; valid = 0; read_valid = 0;
        aw_addr = 0; w_data = 0; w_strb = 0;
        tick();
        tick();
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_ready", ready, 0);
        ARESET = 1'b0;
        tick();
        chk("ready_after_rst", ready, 1);

        // Full-word write to 0x0, B held for 3 cycles with BREADY low.
        valid = 1'b1;
        send_aw(32'h0);
        send_w(32'hDEADBEEF, 4'hF);
        wait_b();
        for (int i = 0; i < 3; i++) begin
            chk("b_hold_valid", BVALID, 1);
            chk("b_hold_resp", BRESP, 2'b00);
            tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("b_drop", BVALID, 0);
        chk("b_ready_back", ready, 1);

        do_read(32'h0, 32'hDEADBEEF, 2'b00);

        // W two cycles ahead of AW, low two lanes only.
        send_w(32'h11223344, 4'h3);
        chk("ready_w_only", ready, 0);
        send_aw(32'h4);
        finish_b(2'b00);
        do_read(32'h4, 32'h00003344, 2'b00);

        // Out of range: 0x100 aliases word 0 in the index bits but must not write it.
        send_aw(32'h100);
        send_w(32'hCAFEF00D, 4'hF);
        finish_b(2'b10);
        do_read(32'h100, 32'h0, 2'b10);
        do_read(32'h0, 32'hDEADBEEF, 2'b00);
        do_read(32'h3C, 32'h0, 2'b00);
        do_read(32'h40, 32'h0, 2'b10);

        // AWVALID blocked by valid=0.
        valid = 1'b0;
        AWADDR = 32'h8; AWVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("aw_blocked", AWREADY, 0);
        end
        valid = 1'b1;
        tick();
        chk("aw_unblocked", AWREADY, 1);
        tick();
        AWVALID = 1'b0;
        chk("aw_unblock_pulse", AWREADY, 0);
        send_w(32'h55AA55AA, 4'hC);
        finish_b(2'b00);
        do_read(32'hA, 32'h55AA0000, 2'b00);

        // ARVALID blocked by read_valid=0.
        read_valid = 1'b0;
        ARADDR = 32'h0; ARVALID = 1'b1;
        tick();
        tick();
        chk("ar_blocked", ARREADY, 0);
        ARVALID = 1'b0;

        // Reset while a B response is pending.
        send_aw(32'hC);
        send_w(32'h12345678, 4'hF);
        wait_b();
        ARESET = 1'b1;
        tick();
        chk("rst_mid_bvalid", BVALID, 0);
        chk("rst_mid_ready", ready, 0);
        ARESET = 1'b0;
        tick();
        chk("rst_mid_ready_back", ready, 1);
        do_read(32'hC, 32'h0, 2'b00);
        do_read(32'h0, 32'h0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
- AXI4-Lite slave with an internal byte-strobed word memory; the peripheral side of the AXI-Lite interconnect, paired with the team's axi_master.
- Independent write path (AW, W, B) and read path (AR, R), one outstanding transaction per path.
- Adds user-side qualifiers: valid, read_valid and an idle flag ready. Also has an optional local preload port.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width; WSTRB width is DATA_W/8.
- DEPTH, 16, memory words; word index = addr[2 +: $clog2(DEPTH)].

Ports:
- ACLK input 1: clock, rising edge.
- ARESET input 1: synchronous, active-high reset.
- AWVALID input 1, AWADDR input ADDR_W, AWREADY output 1: write address channel.
- WVALID input 1, WDATA input DATA_W, WSTRB input DATA_W/8, WREADY output 1: write data channel.
- BREADY input 1, BVALID output 1, BRESP output 2: write response channel.
- ARVALID input 1, ARADDR input ADDR_W, ARREADY output 1: read address channel.
- RREADY input 1, RVALID output 1, RDATA output DATA_W, RRESP output 2: read data channel.
- valid input 1: write enable qualifier; AW and W are accepted only while high.
- read_valid input 1: read enable qualifier; AR is accepted only while high.
- aw_addr input ADDR_W, w_data input DATA_W, w_strb input DATA_W/8: local preload port (optional feature).
- ready output 1: high when both paths are idle.

Behaviour:
- Reset (sync, ARESET=1 at a rising edge):
  - AWREADY, WREADY, BVALID, ARREADY, RVALID, ready = 0; BRESP, RRESP, RDATA = 0.
  - Memory cleared to 0; address and data latches cleared.
  - Any in-flight transaction is dropped with no response.
  - ready = 1 from the first cycle after reset deasserts.
- All outputs are registered.
- AW path:
  - When AWVALID=1, valid=1, no address latched and BVALID=0, AWREADY is driven 1 in the next cycle.
  - Handshake at the edge where AWVALID and AWREADY are both 1: latch AWADDR, and AWREADY returns to 0 in the next cycle (one-cycle pulse).
- W path:
  - Same rule using WVALID, WREADY and valid.
  - On handshake, latch WDATA and WSTRB.
  - W may arrive before, with, or after AW.
- Commit: in the cycle after both address and data are latched:
  - Write byte lane i when WSTRB[i]=1, only if the address is in range (AWADDR < DEPTH*4).
  - Set BVALID=1. BRESP=00 (OKAY) if in range, 10 (SLVERR) if out of range; out-of-range writes modify nothing.
  - Clear both latches.
- B: BVALID and BRESP hold until BREADY=1 at an edge; BVALID drops the next cycle. No new AW or W is accepted while BVALID=1.
- AR path: ARREADY pulses one cycle after ARVALID=1, read_valid=1, no read pending and RVALID=0. On handshake, latch ARADDR.
- R:
  - In the cycle after the AR handshake: RVALID=1; RDATA = memory word (0 if out of range); RRESP = 00 or 10 with the same range rule.
  - RVALID and RDATA hold until RREADY=1; RVALID and RDATA clear the next cycle.
- Unaligned addresses: addr[1:0] is ignored.
- Read and write committing to the same word in the same cycle: the read returns the pre-write data.
- Dropping valid or read_valid mid-transaction does not abort an accepted handshake; it only blocks new acceptance.
- ready = 0 from the first handshake of a transaction through its response handshake.

Optional Feature:
- Macro AXI_SLV_PRELOAD_EN.
- Defined: in a cycle with valid=1, AWVALID=0, no address or data latched and BVALID=0, w_data is written to word aw_addr using w_strb lanes. Out-of-range preloads are ignored. No B response is generated.
- Undefined: aw_addr, w_data and w_strb are ignored.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write-state enum {WR_IDLE, WR_RESP} and read-state enum {RD_IDLE, RD_ADDR, RD_DATA}.
- Sub-module axi_lite_byte_ram: DEPTH x DATA_W memory with a per-byte write enable, a synchronous clear, and an async-read port.

Test Plan:
- Reset, then AW addr 0x0 and W 0xDEADBEEF with strobe 0xF; hold BREADY low 3 cycles -> BVALID held with BRESP=00. BREADY=1 -> BVALID drops the next cycle; ready returns to 1.
- AR addr 0x0 -> ARREADY one-cycle pulse; RVALID with RDATA=0xDEADBEEF, RRESP=00, held until RREADY.
- W presented 2 cycles before AW to addr 0x4 with strobe 0x3 and data 0x11223344, memory previously 0 -> read of 0x4 returns 0x00003344.
- AW to 0x100 (out of range) -> BRESP=10; a read of 0x100 returns RDATA=0 with RRESP=10; a read of 0x0 is unchanged.
- AWVALID=1 with valid=0 for 4 cycles -> AWREADY stays 0; raise valid -> AWREADY pulses the next cycle.
- ARESET asserted while BVALID=1 -> BVALID, ready and memory clear the next cycle; ready=1 after release.
